// File: rtl/lms_pkg.sv
// Shared LMS definitions: default sample width, error-stage FSM states and
// the saturating truncation helper also used by the weight-update block.
package lms_pkg;

  localparam int DATA_W_DEF = 16;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } lms_state_e;

  // Clip a sign-extended value into the two's-complement range of 'width' bits.
  function automatic logic signed [31:0] sat_trunc(input logic signed [31:0] value,
                                                   input int width);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (width - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (width - 1));
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/lms_delay_line.sv
// Sample-enabled shift register with synchronous clear; dout is the entry
// DEPTH samples old, or din itself when DEPTH is 0.
module lms_delay_line #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_bypass
      assign dout = din;
    end else begin : g_line
      logic [WIDTH-1:0] mem [DEPTH];

      always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
          for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (en) begin
          for (int i = DEPTH - 1; i > 0; i--) mem[i] <= mem[i-1];
          mem[0] <= din;
        end
      end

      assign dout = mem[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/lms_error_calc.sv
// LMS error stage: aligns the reference by DELAY samples, forms the saturated
// error and its mu-scaled copy. Optional window statistics under ERR_STATS_EN.
module lms_error_calc
  import lms_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int DELAY    = 9,
  parameter int MU_SHIFT = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     clr_i,
  input  logic                     sample_en_i,
  input  logic signed [DATA_W-1:0] data_ref,
  input  logic signed [DATA_W-1:0] data_in,
  output logic signed [DATA_W-1:0] error_o,
  output logic signed [DATA_W-1:0] mu_err_o,
  output logic                     error_valid_o,
  output logic                     sat_o,
  output lms_state_e               dbg_state
`ifdef ERR_STATS_EN
  ,
  output logic [DATA_W+7:0]        err_acc_o,
  output logic                     stats_valid_o
`endif
);

  localparam int FILL_LAST = (DELAY > 0) ? DELAY - 1 : 0;
  localparam int RND       = (MU_SHIFT == 0) ? 0 : (1 << (MU_SHIFT - 1));

  lms_state_e        state_q, state_d;
  logic [5:0]        fill_cnt, fill_d;
  logic              upd;
  logic [DATA_W-1:0] delayed_ref;

  lms_delay_line #(.WIDTH(DATA_W), .DEPTH(DELAY)) u_dly (
    .clk   (clk_i),
    .rst_n (rst_n_i),
    .clr   (clr_i),
    .en    (sample_en_i),
    .din   (data_ref),
    .dout  (delayed_ref)
  );

  logic signed [DATA_W:0] diff;
  logic signed [31:0]     diff_w;
  logic signed [31:0]     clip_w;
  logic [DATA_W-1:0]      err_sat;
  logic                   sat_flag;
  logic signed [DATA_W:0] mu_sum;
  logic [DATA_W-1:0]      mu_err;

  always_comb begin
    diff     = $signed({delayed_ref[DATA_W-1], delayed_ref}) -
               $signed({data_in[DATA_W-1], data_in});
    diff_w   = 32'(diff);
    clip_w   = sat_trunc(diff_w, DATA_W);
    err_sat  = DATA_W'(clip_w);
    sat_flag = (clip_w != diff_w);
    // One guard bit keeps the rounding add of the positive limit from wrapping.
    mu_sum   = $signed({err_sat[DATA_W-1], err_sat}) + $signed((DATA_W+1)'(RND));
    mu_err   = DATA_W'(mu_sum >>> MU_SHIFT);
  end

  always_comb begin
    state_d = state_q;
    fill_d  = fill_cnt;
    upd     = 1'b0;
    if (sample_en_i) begin
      unique case (state_q)
        ST_FILL: begin
          fill_d = fill_cnt + 6'd1;
          // The sample that completes the fill is already aligned and valid.
          if (DELAY == 0 || fill_cnt == 6'(FILL_LAST)) begin
            state_d = ST_RUN;
            upd     = 1'b1;
          end
        end
        ST_RUN:  upd = 1'b1;
        default: state_d = ST_FILL;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i || clr_i) begin
      state_q       <= ST_FILL;
      fill_cnt      <= '0;
      error_o       <= '0;
      mu_err_o      <= '0;
      error_valid_o <= 1'b0;
      sat_o         <= 1'b0;
    end else begin
      state_q       <= state_d;
      fill_cnt      <= fill_d;
      error_valid_o <= upd;
      if (upd) begin
        error_o  <= err_sat;
        mu_err_o <= mu_err;
        sat_o    <= sat_flag;
      end
    end
  end

  assign dbg_state = state_q;

`ifdef ERR_STATS_EN
  logic [DATA_W-1:0] abs_err;
  logic [DATA_W+7:0] acc;
  logic [7:0]        win_cnt;

  always_comb begin
    if (err_sat == {1'b1, {(DATA_W-1){1'b0}}}) abs_err = {1'b0, {(DATA_W-1){1'b1}}};
    else if (err_sat[DATA_W-1])                abs_err = -err_sat;
    else                                       abs_err = err_sat;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i || clr_i) begin
      acc           <= '0;
      win_cnt       <= '0;
      err_acc_o     <= '0;
      stats_valid_o <= 1'b0;
    end else begin
      stats_valid_o <= 1'b0;
      if (upd) begin
        win_cnt <= win_cnt + 8'd1;
        if (win_cnt == 8'hFF) begin
          err_acc_o     <= acc + (DATA_W+8)'(abs_err);
          acc           <= '0;
          stats_valid_o <= 1'b1;
        end else begin
          acc <= acc + (DATA_W+8)'(abs_err);
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_lms_error_calc.sv
// Directed bench for lms_error_calc: default instance (DELAY=9, MU_SHIFT=4)
// plus a DELAY=0 instance.
module tb_lms_error_calc;
  import lms_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n, clr, en, en0;
  logic signed [15:0] ref_s, din_s, ref0, din0;
  logic signed [15:0] err, mu, err0, mu0;
  logic               valid, sat, valid0, sat0;
  lms_state_e         st, st0;
`ifdef ERR_STATS_EN
  logic [23:0] acc_a, acc_b;
  logic        sv_a, sv_b;
`endif

  lms_error_calc dut (
    .clk_i(clk), .rst_n_i(rst_n), .clr_i(clr), .sample_en_i(en),
    .data_ref(ref_s), .data_in(din_s), .error_o(err), .mu_err_o(mu),
    .error_valid_o(valid), .sat_o(sat), .dbg_state(st)
`ifdef ERR_STATS_EN
    , .err_acc_o(acc_a), .stats_valid_o(sv_a)
`endif
  );

  lms_error_calc #(.DELAY(0)) dut0 (
    .clk_i(clk), .rst_n_i(rst_n), .clr_i(1'b0), .sample_en_i(en0),
    .data_ref(ref0), .data_in(din0), .error_o(err0), .mu_err_o(mu0),
    .error_valid_o(valid0), .sat_o(sat0), .dbg_state(st0)
`ifdef ERR_STATS_EN
    , .err_acc_o(acc_b), .stats_valid_o(sv_b)
`endif
  );

  int n_cmp = 0;
  int n_mis = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  // Drive one cycle on the DELAY=9 instance; outputs sampled 1 time unit after the edge.
  task automatic step(input logic e, input logic c, input logic [15:0] r, input logic [15:0] d);
    @(negedge clk);
    en = e; clr = c; ref_s = r; din_s = d;
    @(posedge clk);
    #1;
    en = 1'b0; clr = 1'b0;
  endtask

  task automatic step0(input logic e, input logic [15:0] r, input logic [15:0] d);
    @(negedge clk);
    en0 = e; ref0 = r; din0 = d;
    @(posedge clk);
    #1;
    en0 = 1'b0;
  endtask

  int t_ref[9] = '{1000, 2000, 3000, 4000, 5000, 6000, 7000, 8000, 9000};
  int s_ref[9] = '{32767, -32768, 24, -24, 7, 8, 100, -5, 1000};
  int s_din[9] = '{-100, 1, 0, 0, 0, 0, 200, 10, -1000};
  int s_err[9] = '{32767, -32768, 24, -24, 7, 8, -100, -15, 2000};
  int s_mu[9]  = '{2048, -2048, 2, -1, 0, 1, -6, -1, 125};
  int s_sat[9] = '{1, 1, 0, 0, 0, 0, 0, 0, 0};
  int g_err[3] = '{-9, 0, 9};
  int g_mu[3]  = '{-1, 0, 1};

  initial begin
    rst_n = 1'b0; clr = 1'b0; en = 1'b0; en0 = 1'b0;
    ref_s = '0; din_s = '0; ref0 = '0; din0 = '0;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check("rst_err", err, 16'd0);
    check("rst_mu", mu, 16'd0);
    check("rst_valid", 16'(valid), 16'd0);
    check("rst_sat", 16'(sat), 16'd0);
    check("rst_state", 16'(st), 16'(ST_FILL));
    rst_n = 1'b1;

    // DELAY=0: the first sample is valid immediately.
    step0(1, 16'(50), 16'(20));
    check("d0_valid", 16'(valid0), 16'd1);
    check("d0_err", err0, 16'(30));
    check("d0_mu", mu0, 16'(2));
    step0(0, 0, 0);
    check("d0_idle_valid", 16'(valid0), 16'd0);
    check("d0_hold_err", err0, 16'(30));
    step0(1, 16'(-32768), 16'(32767));
    check("d0_sat_err", err0, 16'(-32768));
    check("d0_sat_mu", mu0, 16'(-2048));
    check("d0_sat", 16'(sat0), 16'd1);

    // Ramp: refs 1..12 back-to-back, data_in 0.
    for (int n = 1; n <= 12; n++) begin
      step(1, 0, 16'(n), 0);
      check("ramp_valid", 16'(valid), 16'(n >= 9));
      if (n >= 9) begin
        check("ramp_err", err, 16'(n - 9));
        check("ramp_mu", mu, 16'd0);
      end else begin
        check("fill_err", err, 16'd0);
      end
    end
    check("run_state", 16'(st), 16'(ST_RUN));

    // Load directed references while the ramp tail drains out.
    for (int i = 0; i < 9; i++) begin
      step(1, 0, 16'(s_ref[i]), 0);
      exp_q.push_back(16'(s_err[i]));
      check("drain_valid", 16'(valid), 16'd1);
      check("drain_err", err, 16'(i + 4));
      check("drain_mu", mu, 16'((i + 4 >= 8) ? 1 : 0));
      check("drain_sat", 16'(sat), 16'd0);
    end
    // Saturation and rounding vectors against those delayed references.
    for (int i = 0; i < 9; i++) begin
      step(1, 0, 16'(t_ref[i]), 16'(s_din[i]));
      check("vec_valid", 16'(valid), 16'd1);
      check("vec_err", err, exp_q.pop_front());
      check("vec_mu", mu, 16'(s_mu[i]));
      check("vec_sat", 16'(sat), 16'(s_sat[i]));
    end
    step(0, 0, 0, 0);
    check("idle_valid", 16'(valid), 16'd0);
    check("hold_err", err, 16'(2000));
    check("hold_mu", mu, 16'(125));

    // Clear together with a sample: sample dropped, everything zeroed.
    step(1, 1, 16'(555), 0);
    check("clr_valid", 16'(valid), 16'd0);
    check("clr_err", err, 16'd0);
    check("clr_mu", mu, 16'd0);
    check("clr_state", 16'(st), 16'(ST_FILL));

    // Gapped enable: one sample every third cycle.
    for (int n = 1; n <= 11; n++) begin
      step(1, 0, 16'(10 * n), 16'(n));
      check("gap_valid", 16'(valid), 16'(n >= 9));
      if (n >= 9) begin
        check("gap_err", err, 16'(g_err[n-9]));
        check("gap_mu", mu, 16'(g_mu[n-9]));
      end else begin
        check("gap_fill_err", err, 16'd0);
      end
      step(0, 0, 0, 0);
      check("gap_idle1", 16'(valid), 16'd0);
      step(0, 0, 0, 0);
      check("gap_idle2", 16'(valid), 16'd0);
    end
    check("gap_hold_err", err, 16'(9));

    // Reset for one cycle mid-run behaves like clear.
    rst_n = 1'b0;
    step(1, 0, 16'(777), 0);
    rst_n = 1'b1;
    check("mrst_valid", 16'(valid), 16'd0);
    check("mrst_err", err, 16'd0);
    check("mrst_mu", mu, 16'd0);
    check("mrst_state", 16'(st), 16'(ST_FILL));
    for (int n = 1; n <= 10; n++) begin
      step(1, 0, 16'(100 + n), 0);
      check("mrst_fill_valid", 16'(valid), 16'(n >= 9));
    end
    check("mrst_err10", err, 16'(101));
    check("mrst_mu10", mu, 16'(6));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
